// File: rtl/fir_decim_serializer.sv
// fir_decim_serializer: buffers 8 x NB-bit FIR output words in a small
// FIFO and streams them as one channel sample per valid/ready beat.
// Ports: c, reset_n (async, active-low); id/iv word in, strobe only,
// no upstream ready; od/och/olast/ov/ordy beat stream out;
// ovf/ovf_clr sticky drop flag and its clear; level = words held,
// including the word being emitted.
// Option: FIR_SER_CHMASK_EN adds chmask, a per-word channel enable mask.
module fir_decim_serializer #(
  parameter int NCH   = 8,
  parameter int NB    = 24,
  parameter int DEPTH = 4
) (
  input  logic                     c,
  input  logic                     reset_n,
  input  logic [NCH*NB-1:0]        id,
  input  logic                     iv,
  output logic [NB-1:0]            od,
  output logic [2:0]               och,
  output logic                     olast,
  output logic                     ov,
  input  logic                     ordy,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic [$clog2(DEPTH):0]   level
`ifdef FIR_SER_CHMASK_EN
  ,
  input  logic [NCH-1:0]           chmask
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(NCH);

  logic [NCH*NB-1:0] mem [DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic [LW-1:0]     lvl;
  logic [CW-1:0]     ch;
  logic              ovf_q;

  logic [NCH-1:0]    cm;
  logic [NCH-1:0]    msk;
  logic [NCH*NB-1:0] head;

  logic vld;
  logic last;
  logic full;
  logic empty;
  logic beat;
  logic pop;
  logic adv;
  logic push;
  logic drop;
  logic start;
  logic load;

  function automatic logic [CW-1:0] lo_idx(
    input logic [NCH-1:0] m
  );
    logic [CW-1:0] r;
    r = '0;
    for (int k = NCH - 1; k >= 0; k--)
      if (m[k]) r = CW'(k);
    return r;
  endfunction

  function automatic logic [CW-1:0] hi_idx(
    input logic [NCH-1:0] m
  );
    logic [CW-1:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++)
      if (m[k]) r = CW'(k);
    return r;
  endfunction

  // Next enabled channel strictly above cur.
  function automatic logic [CW-1:0] nx_idx(
    input logic [NCH-1:0] m,
    input logic [CW-1:0]  cur
  );
    logic [CW-1:0] r;
    logic          hit;
    r   = cur;
    hit = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!hit && m[k] && (k > int'(cur))) begin
        r   = CW'(k);
        hit = 1'b1;
      end
    end
    return r;
  endfunction

`ifdef FIR_SER_CHMASK_EN
  // An all-zero mask means every channel is enabled.
  assign cm = (chmask == '0) ? '1 : chmask;

  // Mask is latched when a word becomes head, so a mid-word
  // change only affects the following word.
  always_ff @(posedge c or negedge reset_n) begin
    if (!reset_n) begin
      msk <= '1;
    end else if (load) begin
      msk <= cm;
    end
  end
`else
  assign cm  = '1;
  assign msk = '1;
`endif

  assign empty = (lvl == '0);
  assign full  = (lvl == LW'(DEPTH));
  assign vld   = ~empty;
  assign last  = (ch == hi_idx(msk));
  assign beat  = vld & ordy;
  assign pop   = beat & last;
  assign adv   = beat & ~last;

  // A full FIFO still takes a word when its head leaves this cycle.
  assign push  = iv & (~full | pop);
  assign drop  = iv & full & ~pop;

  // First word into an empty FIFO starts its channel walk here.
  assign start = push & empty;
  assign load  = pop | start;

  assign head  = mem[rp];

  assign ov    = vld;
  assign od    = vld ? head[NB*int'(ch) +: NB] : '0;
  assign och   = vld ? 3'(ch) : 3'd0;
  assign olast = vld & last;
  assign ovf   = ovf_q;
  assign level = lvl;

  always_ff @(posedge c) begin
    if (push) begin
      mem[wp] <= id;
    end
  end

  always_ff @(posedge c or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge c or negedge reset_n) begin
    if (!reset_n) begin
      lvl <= '0;
    end else begin
      unique case (1'b1)
        push & ~pop: lvl <= lvl + 1'b1;
        pop & ~push: lvl <= lvl - 1'b1;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge c or negedge reset_n) begin
    if (!reset_n) begin
      ch <= '0;
    end else begin
      unique case (1'b1)
        load:    ch <= lo_idx(cm);
        adv:     ch <= nx_idx(msk, ch);
        default: ;
      endcase
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge c or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_decim_serializer.sv
// tb_fir_decim_serializer: randomized self-checking bench against a
// queue-based model of the word FIFO and beat stream.
module tb_fir_decim_serializer;

  localparam int NCH   = 8;
  localparam int NB    = 24;
  localparam int DEPTH = 4;

  logic         c = 1'b0;
  logic         reset_n;
  logic [191:0] id;
  logic         iv;
  logic         ordy;
  logic         ovf_clr;
  logic [23:0]  od;
  logic [2:0]   och;
  logic         olast;
  logic         ov;
  logic         ovf;
  logic [2:0]   level;
`ifdef FIR_SER_CHMASK_EN
  logic [7:0]   chmask;
`endif

  int tests = 0;
  int fails = 0;

  logic [191:0] mq [$];
  int           mbeat;
  bit           movf;

  logic [32:0]  got;
  logic [32:0]  want;

  assign got = {ov, od, och, olast, level, ovf};

  fir_decim_serializer #(
    .NCH   (NCH),
    .NB    (NB),
    .DEPTH (DEPTH)
  ) dut (
    .c       (c),
    .reset_n (reset_n),
    .id      (id),
    .iv      (iv),
    .od      (od),
    .och     (och),
    .olast   (olast),
    .ov      (ov),
    .ordy    (ordy),
    .ovf     (ovf),
    .ovf_clr (ovf_clr),
    .level   (level)
`ifdef FIR_SER_CHMASK_EN
    ,
    .chmask  (chmask)
`endif
  );

  always #5 c = ~c;

  function automatic logic [7:0] eff_mask();
`ifdef FIR_SER_CHMASK_EN
    return (chmask == 8'd0) ? 8'hFF : chmask;
`else
    return 8'hFF;
`endif
  endfunction

  function automatic int nbeats();
    return $countones(eff_mask());
  endfunction

  // n-th enabled channel in ascending order.
  function automatic int nth_ch(input int n);
    logic [7:0] m;
    int         cnt;
    m   = eff_mask();
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (m[k]) begin
        if (cnt == n) return k;
        cnt++;
      end
    end
    return 0;
  endfunction

  function automatic logic [32:0] model_out();
    logic [191:0] w;
    logic [23:0]  d;
    logic [2:0]   ch;
    logic         l;
    d  = '0;
    ch = '0;
    l  = 1'b0;
    if (mq.size() != 0) begin
      w  = mq[0];
      ch = 3'(nth_ch(mbeat));
      d  = w[24*ch +: 24];
      l  = (mbeat == nbeats() - 1);
    end
    return {mq.size() != 0, d, ch, l, 3'(mq.size()), movf};
  endfunction

  function automatic logic [191:0] rand_word();
    logic [191:0] w;
    for (int k = 0; k < 8; k++) w[24*k +: 24] = 24'($urandom);
    return w;
  endfunction

  // Advance one clock: apply the stream rules to the model at the
  // rising edge, then return at the falling edge for sampling.
  task automatic tick();
    bit fire;
    bit popm;
    bit drop;
    @(posedge c);
    fire = (mq.size() != 0) && ordy;
    popm = fire && (mbeat == nbeats() - 1);
    drop = 1'b0;
    if (fire) mbeat = popm ? 0 : mbeat + 1;
    if (popm) void'(mq.pop_front());
    if (iv) begin
      if (mq.size() < DEPTH) mq.push_back(id);
      else drop = 1'b1;
    end
    if (drop) movf = 1'b1;
    else if (ovf_clr) movf = 1'b0;
    @(negedge c);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge c);
    tests++;
    if (got !== 33'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h want 0", got);
    end
    reset_n = 1'b1;
    tick();
    want = model_out();
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL reset_idle: got %h want %h", got, want);
    end
  endtask

  task automatic test_stream();
    logic [191:0] w;
    int lastn;
    lastn = 0;
    ordy  = 1'b1;
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 8; k++)
        w[24*k +: 24] = (n == 0) ? 24'h100000 + 24'(k) : 24'($urandom);
      id = w;
      iv = 1'b1;
      tick();
      iv = 1'b0;
      tests++;
      if (ov !== 1'b1) begin
        fails++;
        $display("FAIL stream_latency: ov %b want 1", ov);
      end
      if (n == 0) begin
        tests++;
        if (od !== 24'h100000) begin
          fails++;
          $display("FAIL stream_first_od: got %h want 100000", od);
        end
      end
      for (int i = 0; i < 31; i++) begin
        want = model_out();
        tests++;
        if (got !== want) begin
          fails++;
          $display("FAIL stream_beat: got %h want %h", got, want);
        end
        tests++;
        if (level > 3'd1) begin
          fails++;
          $display("FAIL stream_level: got %0d want <=1", level);
        end
        if (ov && ordy && olast) lastn++;
        tick();
      end
    end
    tests++;
    if (lastn !== 3) begin
      fails++;
      $display("FAIL stream_olast_count: got %0d want 3", lastn);
    end
  endtask

  task automatic test_overflow();
    ordy = 1'b0;
    for (int n = 0; n < 5; n++) begin
      id = rand_word();
      iv = 1'b1;
      tick();
    end
    iv = 1'b0;
    tests++;
    if (level !== 3'd4) begin
      fails++;
      $display("FAIL ovf_level: got %0d want 4", level);
    end
    tests++;
    if (ovf !== 1'b1) begin
      fails++;
      $display("FAIL ovf_set: got %b want 1", ovf);
    end
    ordy = 1'b1;
    for (int i = 0; i < 36; i++) begin
      want = model_out();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL ovf_drain: got %h want %h", got, want);
      end
      tests++;
      if (ovf !== 1'b1) begin
        fails++;
        $display("FAIL ovf_sticky: got %b want 1", ovf);
      end
      tick();
    end
    tests++;
    if (level !== 3'd0) begin
      fails++;
      $display("FAIL ovf_empty: got %0d want 0", level);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tests++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear: got %b want 0", ovf);
    end
  endtask

  task automatic test_full_push();
    bit found;
    found = 1'b0;
    ordy  = 1'b0;
    for (int n = 0; n < 4; n++) begin
      id = rand_word();
      iv = 1'b1;
      tick();
    end
    iv   = 1'b0;
    ordy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      want = model_out();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL full_beat: got %h want %h", got, want);
      end
      if (mbeat == 7) begin
        id = rand_word();
        iv = 1'b1;
        tick();
        iv = 1'b0;
        tests++;
        if (level !== 3'd4) begin
          fails++;
          $display("FAIL full_push_level: got %0d want 4", level);
        end
        tests++;
        if (ovf !== 1'b0) begin
          fails++;
          $display("FAIL full_push_ovf: got %b want 0", ovf);
        end
        found = 1'b1;
        break;
      end
      tick();
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL full_no_last: got none want olast beat");
    end
    for (int i = 0; i < 36; i++) begin
      want = model_out();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL full_drain: got %h want %h", got, want);
      end
      tick();
    end
  endtask

  task automatic test_hold();
    logic [11:0] pat;
    logic [26:0] prev;
    pat  = 12'b1111_1110_0111;
    prev = '0;
    ordy = 1'b1;
    id   = rand_word();
    iv   = 1'b1;
    tick();
    iv   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ordy = pat[i];
      want = model_out();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL hold_beat: got %h want %h", got, want);
      end
      if (i > 0 && !pat[i-1]) begin
        tests++;
        if ({od, och} !== prev) begin
          fails++;
          $display("FAIL hold_stable: got %h want %h", {od, och}, prev);
        end
      end
      prev = {od, och};
      tick();
    end
    ordy = 1'b1;
  endtask

  task automatic test_async_reset();
    ordy = 1'b1;
    id   = rand_word();
    iv   = 1'b1;
    tick();
    iv   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      want = model_out();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL arst_pre: got %h want %h", got, want);
      end
      tick();
    end
    tests++;
    if (och !== 3'd3) begin
      fails++;
      $display("FAIL arst_och3: got %0d want 3", och);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (got !== 33'd0) begin
      fails++;
      $display("FAIL arst_immediate: got %h want 0", got);
    end
    mq.delete();
    mbeat = 0;
    movf  = 1'b0;
    #1 reset_n = 1'b1;
    @(negedge c);
    id = rand_word();
    iv = 1'b1;
    tick();
    iv = 1'b0;
    tests++;
    if ({och, level} !== {3'd0, 3'd1}) begin
      fails++;
      $display("FAIL arst_restart: got och %0d lvl %0d want 0 1",
               och, level);
    end
    for (int i = 0; i < 10; i++) begin
      want = model_out();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL arst_word: got %h want %h", got, want);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      iv      = ($urandom_range(0, 11) == 0);
      id      = rand_word();
      ordy    = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 19) == 0);
      want = model_out();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL rand_beat: cyc %0d got %h want %h", i, got, want);
      end
      tick();
    end
    iv      = 1'b0;
    ordy    = 1'b1;
    ovf_clr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      want = model_out();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL rand_drain: got %h want %h", got, want);
      end
      tick();
    end
  endtask

`ifdef FIR_SER_CHMASK_EN
  task automatic test_chmask();
    logic [11:0] seq;
    int nb;
    int n8;
    seq    = '0;
    nb     = 0;
    n8     = 0;
    ordy   = 1'b1;
    chmask = 8'b1010_0101;
    id     = rand_word();
    iv     = 1'b1;
    tick();
    iv     = 1'b0;
    for (int i = 0; i < 10; i++) begin
      want = model_out();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL mask_beat: got %h want %h", got, want);
      end
      if (ov && nb < 4) begin
        seq[3*nb +: 3] = och;
        nb++;
      end
      tick();
    end
    tests++;
    if (seq !== {3'd7, 3'd5, 3'd2, 3'd0}) begin
      fails++;
      $display("FAIL mask_order: got %h want %h", seq,
               {3'd7, 3'd5, 3'd2, 3'd0});
    end
    chmask = 8'd0;
    id     = rand_word();
    iv     = 1'b1;
    tick();
    iv     = 1'b0;
    for (int i = 0; i < 12; i++) begin
      want = model_out();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL mask_all: got %h want %h", got, want);
      end
      if (ov) n8++;
      tick();
    end
    tests++;
    if (n8 !== 8) begin
      fails++;
      $display("FAIL mask_zero_count: got %0d want 8", n8);
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    iv      = 1'b0;
    ordy    = 1'b0;
    ovf_clr = 1'b0;
    id      = '0;
`ifdef FIR_SER_CHMASK_EN
    chmask  = 8'd0;
`endif
    mq.delete();
    mbeat = 0;
    movf  = 1'b0;
    test_reset();
    test_stream();
    test_overflow();
    test_full_push();
    test_hold();
    test_async_reset();
    test_random();
`ifdef FIR_SER_CHMASK_EN
    test_chmask();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
